// File: rtl/uart_pkg.sv
// Shared UART definitions: frame FSM states, system clock and default baud constants,
// and the parity helper used by both directions of the link.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_t;

    localparam int CLK_HZ               = 100_000_000;
    localparam int DEFAULT_BAUD         = 115_200;
    localparam int DEFAULT_CLKS_PER_BIT = CLK_HZ / DEFAULT_BAUD;
    localparam int RX_OVERSAMPLE        = 16;

    // Unused upper bits must be zero so they do not disturb the XOR.
    function automatic logic calc_parity(input logic [7:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_tx_serializer_if.sv
// Parallel byte handshake into the UART transmitter: the source drives data/valid,
// the transmitter answers with ready.
interface uart_tx_serializer_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] data_in;
    logic                 valid_in;
    logic                 ready_out;

    modport master (output data_in, output valid_in, input ready_out);
    modport slave  (input data_in, input valid_in, output ready_out);
endinterface

// File: rtl/uart_baud_tick.sv
// Free-running bit-period divider: counts 0..CLKS_PER_TICK-1, pulses o_tick on the
// wrap cycle, and restarts from zero whenever i_clear is high.
module uart_baud_tick #(
    parameter int CLKS_PER_TICK = 868,
    parameter int CNT_W         = (CLKS_PER_TICK > 1) ? $clog2(CLKS_PER_TICK) : 1
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    input  logic             i_clear,
    output logic             o_tick,
    output logic [CNT_W-1:0] o_count
);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_TICK - 1);

    logic [CNT_W-1:0] r_cnt;

    // Divider counter with synchronous clear and wrap at the last count.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (r_cnt == CNT_LAST) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign o_tick  = (r_cnt == CNT_LAST);
    assign o_count = r_cnt;
endmodule

// File: rtl/uart_tx_serializer.sv
// UART transmitter: takes bytes over a valid/ready handshake and shifts them out
// LSB first as start / data / optional parity / stop bits on a registered TX line.
module uart_tx_serializer
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk_in,
    input  logic                 rst_n_in,
    uart_tx_serializer_if.slave  bus,
    output logic                 tx_out,
    output logic                 busy_out
);
    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IDX_W = $clog2(DATA_BITS + 1);
    localparam logic [CNT_W-1:0] CNT_PRE_LAST = CNT_W'(CLKS_PER_BIT - 2);
    localparam logic [IDX_W-1:0] IDX_LAST     = IDX_W'(DATA_BITS - 1);
    localparam logic             STOP_LAST    = (STOP_BITS == 2) ? 1'b1 : 1'b0;

    tx_state_t            r_state;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_parity;
    logic [IDX_W-1:0]     r_bit_idx;
    logic                 r_stop_idx;
    logic                 r_tx;
    logic                 r_busy;
    logic                 r_ready;

    logic                 w_accept;
    logic                 w_clear;
    logic                 w_tick;
    logic [CNT_W-1:0]     w_count;
    logic [7:0]           w_data_ext;

    assign w_accept   = bus.valid_in && r_ready;
    assign w_clear    = (r_state == IDLE) || w_accept;
    assign w_data_ext = 8'(bus.data_in);

    uart_baud_tick #(
        .CLKS_PER_TICK (CLKS_PER_BIT),
        .CNT_W         (CNT_W)
    ) u_baud_tick (
        .clk_in   (clk_in),
        .rst_n_in (rst_n_in),
        .i_clear  (w_clear),
        .o_tick   (w_tick),
        .o_count  (w_count)
    );

    // Frame sequencer; every output is a flop so the line never sees an input glitch.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_state    <= IDLE;
            r_shift    <= '0;
            r_parity   <= 1'b0;
            r_bit_idx  <= '0;
            r_stop_idx <= 1'b0;
            r_tx       <= 1'b1;
            r_busy     <= 1'b0;
            r_ready    <= 1'b1;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_shift  <= bus.data_in;
                        r_parity <= calc_parity(w_data_ext, PARITY_ODD != 0);
                        r_state  <= START;
                        r_tx     <= 1'b0;
                        r_busy   <= 1'b1;
                        r_ready  <= 1'b0;
                    end else begin
                        r_tx    <= 1'b1;
                        r_busy  <= 1'b0;
                        r_ready <= 1'b1;
                    end
                end
                START: begin
                    if (w_tick) begin
                        r_state   <= DATA;
                        r_tx      <= r_shift[0];
                        r_shift   <= r_shift >> 1;
                        r_bit_idx <= '0;
                    end else begin
                        r_tx <= 1'b0;
                    end
                end
                DATA: begin
                    if (w_tick) begin
                        if (r_bit_idx != IDX_LAST) begin
                            r_bit_idx <= r_bit_idx + IDX_W'(1);
                            r_tx      <= r_shift[0];
                            r_shift   <= r_shift >> 1;
                        end else if (PARITY_EN != 0) begin
                            r_state <= PARITY;
                            r_tx    <= r_parity;
                        end else begin
                            r_state    <= STOP;
                            r_tx       <= 1'b1;
                            r_stop_idx <= 1'b0;
                        end
                    end else begin
                        r_tx <= r_tx;
                    end
                end
                PARITY: begin
                    if (w_tick) begin
                        r_state    <= STOP;
                        r_tx       <= 1'b1;
                        r_stop_idx <= 1'b0;
                    end else begin
                        r_tx <= r_parity;
                    end
                end
                STOP: begin
                    // Ready is raised one cycle early so it is visible in the last stop cycle.
                    if (w_tick) begin
                        if (r_stop_idx != STOP_LAST) begin
                            r_stop_idx <= 1'b1;
                        end else if (w_accept) begin
                            r_shift  <= bus.data_in;
                            r_parity <= calc_parity(w_data_ext, PARITY_ODD != 0);
                            r_state  <= START;
                            r_tx     <= 1'b0;
                            r_busy   <= 1'b1;
                            r_ready  <= 1'b0;
                        end else begin
                            r_state <= IDLE;
                            r_tx    <= 1'b1;
                            r_busy  <= 1'b0;
                            r_ready <= 1'b1;
                        end
                    end else if ((r_stop_idx == STOP_LAST) && (w_count == CNT_PRE_LAST)) begin
                        r_ready <= 1'b1;
                    end else begin
                        r_ready <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_tx    <= 1'b1;
                    r_busy  <= 1'b0;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

    assign tx_out        = r_tx;
    assign busy_out      = r_busy;
    assign bus.ready_out = r_ready;
endmodule
